// File: rtl/adc_pkg.sv
// Shared types and constants for the temperature ADC front end.
// Holds the frame FSM encoding and the parameter sanity check.
package adc_pkg;

  localparam int ADC_BITS     = 16;
  localparam int SHIFT_HALVES = 2 * ADC_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_ACCUM
  } adc_state_e;

  function automatic bit cfg_ok(
    input int clk_div,
    input int period,
    input int avg_log2
  );
    return (clk_div >= 1) && (period >= 2) &&
           (avg_log2 >= 0) && (avg_log2 <= 4);
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SCLK generator and MSB-first capture shift register for one frame.
// A frame is 16 low/high SCLK periods, ending on the 16th falling edge.
module adc_spi_shifter
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                miso_i,
  output logic                sclk_o,
  output logic                done_o,
  output logic [ADC_BITS-1:0] data_o
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int HW = $clog2(SHIFT_HALVES);

  logic                active_q;
  logic [DW-1:0]       div_q;
  logic [HW-1:0]       half_q;
  logic                sclk_q;
  logic [ADC_BITS-1:0] sr_q;
  logic                div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));
  assign done_o  = active_q && div_end &&
                   (half_q == HW'(SHIFT_HALVES - 1));
  assign sclk_o  = sclk_q;
  assign data_o  = sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
      sr_q     <= '0;
    end else if (abort_i) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      if (div_end) begin
        div_q  <= '0;
        half_q <= half_q + 1'b1;
        sclk_q <= ~sclk_q;
        // capture on the edge that raises SCLK
        if (!sclk_q) sr_q <= {sr_q[ADC_BITS-2:0], miso_i};
        if (done_o) active_q <= 1'b0;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// Periodic ADC read sequencer with power-of-two averaging.
// Emits the truncated mean of 2^AVG_LOG2 conversions with a 1-cycle strobe.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_miso,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int WW = $clog2(CLK_DIV) + 1;
  localparam int AW = ADC_BITS + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] N_AVG = CW'(1) << AVG_LOG2;

  if (!cfg_ok(CLK_DIV, SAMPLE_PERIOD, AVG_LOG2)) begin : g_bad_cfg
    $error("adc_sampler: illegal parameters");
  end

  adc_state_e          state_q;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [WW-1:0]       wcnt_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       cnt_q;
  logic                cs_n_q, valid_q, busy_q, ovr_q;
  logic [ADC_BITS-1:0] data_q;
  logic [ADC_BITS-1:0] shift_data;
  logic                tick, wend, start, done;

  assign wend  = (wcnt_q == WW'(CLK_DIV - 1));
  assign start = (state_q == ST_SETUP) && wend;

  always_comb begin
    tick   = enable && (pcnt_q == PW'(SAMPLE_PERIOD - 1));
    pcnt_d = '0;
    if (enable && !tick) pcnt_d = pcnt_q + 1'b1;
  end

  adc_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .abort_i (!enable),
    .miso_i  (adc_miso),
    .sclk_o  (adc_sclk),
    .done_o  (done),
    .data_o  (shift_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (!enable) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      valid_q <= 1'b0;
      if (tick && busy_q) ovr_q <= 1'b1;
      if (cnt_q == N_AVG) begin
        data_q  <= acc_q[AW-1:AVG_LOG2];
        valid_q <= 1'b1;
        acc_q   <= '0;
        cnt_q   <= '0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            wcnt_q  <= '0;
          end
        end
        ST_SETUP: begin
          if (wend) begin
            state_q <= ST_SHIFT;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (done) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (wend) begin
            state_q <= ST_ACCUM;
            cs_n_q  <= 1'b1;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_q   <= acc_q + AW'(shift_data);
          cnt_q   <= cnt_q + 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_data  = data_q;
  assign adc_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: four instances with different configs,
// each fed by a behavioural serial ADC that shifts on SCLK falling edges.
module tb_adc_sampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    [4];
  logic        cs_n  [4];
  logic        sclk  [4];
  logic        miso  [4] = '{default: 1'b0};
  logic        valid [4];
  logic        busy  [4];
  logic        ovr   [4];
  logic [15:0] data  [4];

  logic [15:0] wtab [4][32];
  int          fidx [4] = '{default: 0};
  logic [15:0] sr_m [4] = '{default: 16'h0};
  logic        cs_prev   [4] = '{default: 1'b1};
  logic        sclk_prev [4] = '{default: 1'b0};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(0)) u_avg0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_miso(miso[0]),
    .adc_data(data[0]), .adc_valid(valid[0]),
    .busy(busy[0]), .overrun(ovr[0]));

  adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(2)) u_avg2 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_miso(miso[1]),
    .adc_data(data[1]), .adc_valid(valid[1]),
    .busy(busy[1]), .overrun(ovr[1]));

  adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(4)) u_avg4 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]),
    .adc_cs_n(cs_n[2]), .adc_sclk(sclk[2]), .adc_miso(miso[2]),
    .adc_data(data[2]), .adc_valid(valid[2]),
    .busy(busy[2]), .overrun(ovr[2]));

  adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(50), .AVG_LOG2(0)) u_ovr (
    .clk(clk), .rst_n(rst_n), .enable(en[3]),
    .adc_cs_n(cs_n[3]), .adc_sclk(sclk[3]), .adc_miso(miso[3]),
    .adc_data(data[3]), .adc_valid(valid[3]),
    .busy(busy[3]), .overrun(ovr[3]));

  // ADC model: load next word on CS fall, advance on SCLK fall
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cs_prev[i] === 1'b1 && cs_n[i] === 1'b0) begin
        sr_m[i] = wtab[i][fidx[i]];
        fidx[i] = (fidx[i] + 1) % 32;
      end else if (sclk_prev[i] === 1'b1 && sclk[i] === 1'b0) begin
        sr_m[i] = {sr_m[i][14:0], 1'b0};
      end
      miso[i]      = sr_m[i][15];
      cs_prev[i]   = cs_n[i];
      sclk_prev[i] = sclk[i];
    end
  end

  task automatic wait_cs_fall(input int i, input int maxc, output int n);
    n = -1;
    for (int c = 1; c <= maxc && n < 0; c++) begin
      @(negedge clk);
      if (cs_n[i] === 1'b0) n = c;
    end
  endtask

  task automatic watch_valid(input int i, input int ncyc, output int nv,
                             output int first, output logic [15:0] d);
    nv = 0;
    first = -1;
    d = 16'h0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (valid[i] === 1'b1) begin
        nv++;
        if (first < 0) begin
          first = c;
          d = data[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    int lows;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0;
      for (int k = 0; k < 32; k++) wtab[i][k] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cs_n[i], sclk[i], valid[i], busy[i], ovr[i]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b%b%b%b%b want 10000", i,
                 cs_n[i], sclk[i], valid[i], busy[i], ovr[i]);
      end
      checks++;
      if (data[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h want 0000", i, data[i]);
      end
    end
    rst_n = 1'b1;
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (cs_n[1] !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL idle_disabled: got %0d cs low cycles want 0", lows);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    en[1] = 1'b1;
    wait_cs_fall(1, 200, n);
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL first_cs_fall: got %0d want 100", n);
    end
    n = 0;
    for (int c = 0; c < 20 && sclk[1] !== 1'b1; c++) @(negedge clk);
    checks++;
    if ({sclk[1], busy[1], cs_n[1]} !== 3'b110) begin
      errors++;
      $display("FAIL mid_shift: got sclk/busy/cs %b%b%b want 110",
               sclk[1], busy[1], cs_n[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_n[1], sclk[1], valid[1], busy[1], ovr[1]} !== 5'b10000 ||
        data[1] !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got %b%b%b%b%b %h want 10000 0000",
               cs_n[1], sclk[1], valid[1], busy[1], ovr[1], data[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cs_fall(1, 200, n);
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL cs_after_reset: got %0d want 100", n);
    end
  endtask

  task automatic test_avg0();
    int n, nv, first;
    logic [15:0] d;
    for (int k = 0; k < 32; k++) wtab[0][k] = 16'h0008;
    en[0] = 1'b1;
    wait_cs_fall(0, 200, n);
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL avg0_cs_fall: got %0d want 100", n);
    end
    watch_valid(0, 75, nv, first, d);
    checks++;
    if (nv != 1 || first != 70) begin
      errors++;
      $display("FAIL avg0_strobe: got %0d pulses at %0d want 1 at 70",
               nv, first);
    end
    checks++;
    if (d !== 16'h0008) begin
      errors++;
      $display("FAIL avg0_data: got %h want 0008", d);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_avg2_mean();
    int base, nv, first;
    logic [15:0] d;
    logic [15:0] smp [4];
    smp = '{16'h0010, 16'h0020, 16'h0030, 16'h0041};
    en[1] = 1'b0;
    repeat (2) @(negedge clk);
    base = fidx[1];
    for (int k = 0; k < 4; k++) wtab[1][(base + k) % 32] = smp[k];
    en[1] = 1'b1;
    watch_valid(1, 480, nv, first, d);
    checks++;
    if (nv != 1 || first != 470) begin
      errors++;
      $display("FAIL avg2_strobe: got %0d pulses at %0d want 1 at 470",
               nv, first);
    end
    checks++;
    if (d !== 16'h0028) begin
      errors++;
      $display("FAIL avg2_data: got %h want 0028", d);
    end
    checks++;
    if (ovr[1] !== 1'b0) begin
      errors++;
      $display("FAIL avg2_no_overrun: got %b want 0", ovr[1]);
    end
  endtask

  task automatic test_abort();
    int base, nv, first;
    logic [15:0] d;
    en[1] = 1'b0;
    repeat (2) @(negedge clk);
    base = fidx[1];
    wtab[1][base % 32]       = 16'h7777;
    wtab[1][(base + 1) % 32] = 16'h5555;
    en[1] = 1'b1;
    repeat (236) @(negedge clk);
    checks++;
    if ({cs_n[1], sclk[1]} !== 2'b01) begin
      errors++;
      $display("FAIL abort_setup: got cs/sclk %b%b want 01",
               cs_n[1], sclk[1]);
    end
    en[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_n[1], sclk[1], busy[1]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_outputs: got cs/sclk/busy %b%b%b want 100",
               cs_n[1], sclk[1], busy[1]);
    end
    checks++;
    if (data[1] !== 16'h0028) begin
      errors++;
      $display("FAIL abort_hold_data: got %h want 0028", data[1]);
    end
    watch_valid(1, 10, nv, first, d);
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL abort_no_strobe: got %0d pulses want 0", nv);
    end
    base = fidx[1];
    for (int k = 0; k < 4; k++) wtab[1][(base + k) % 32] = 16'h0100;
    en[1] = 1'b1;
    watch_valid(1, 480, nv, first, d);
    checks++;
    if (nv != 1 || first != 470 || d !== 16'h0100) begin
      errors++;
      $display("FAIL abort_discard: got %0d pulses at %0d data %h want 1 at 470 data 0100",
               nv, first, d);
    end
    en[1] = 1'b0;
  endtask

  task automatic test_avg4_full_scale();
    int nv, first;
    logic [15:0] d;
    for (int k = 0; k < 32; k++) wtab[2][k] = 16'hFFFF;
    en[2] = 1'b1;
    watch_valid(2, 1700, nv, first, d);
    checks++;
    if (nv != 1 || first != 1670) begin
      errors++;
      $display("FAIL avg4_strobe: got %0d pulses at %0d want 1 at 1670",
               nv, first);
    end
    checks++;
    if (d !== 16'hFFFF) begin
      errors++;
      $display("FAIL avg4_data: got %h want ffff", d);
    end
    en[2] = 1'b0;
  endtask

  task automatic test_overrun();
    en[3] = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (ovr[3] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got %b want 0", ovr[3]);
    end
    repeat (90) @(negedge clk);
    checks++;
    if (ovr[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got %b want 1", ovr[3]);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (ovr[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got %b want 1", ovr[3]);
    end
    en[3] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ovr[3], cs_n[3], busy[3]} !== 3'b010) begin
      errors++;
      $display("FAIL ovr_clear: got ovr/cs/busy %b%b%b want 010",
               ovr[3], cs_n[3], busy[3]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_avg0();
    test_avg2_mean();
    test_abort();
    test_avg4_full_scale();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
